sha256_w_sched: RTL and testbench

- Message-schedule stage feeding the SHA-224/256 round logic.
- On init or next, latches one 512-bit message block and produces one schedule word W_t per advance for t = 0..63.
- Uses a 16-word sliding window.
- Sits directly upstream of the round datapath, which consumes `w` at the same round index as its own round counter.

---
 rtl/sha256_w_sched.sv | 85 ++++++++
 tb/tb_sha256_w_sched.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/sha256_w_sched.sv
// SHA-224/256 message schedule: 16-word sliding window producing one W_t per advance.
// Define SHA256_W_SCHED_ZEROIZE_EN to clear the window on completion and while idle.
module sha256_w_sched #(
    parameter int unsigned ROUNDS = 64
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         init,
    input  logic         next,
    input  logic [511:0] block,
    output logic [31:0]  w,
    output logic         w_valid,
    output logic [5:0]   t_ctr,
    output logic         ready
);
    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACTIVE = 1'b1;
    localparam logic [5:0] LAST   = 6'(ROUNDS - 1);

    logic [0:0]  state;
    logic [31:0] win [16];
    logic [31:0] w_new;
    logic        load;
    logic        adv;
    logic        done;

    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    // init has priority over next in every state
    always_comb begin
        load  = init | (next & (state == IDLE));
        adv   = next & ~init & (state == ACTIVE) & (t_ctr != LAST);
        done  = next & ~init & (state == ACTIVE) & (t_ctr == LAST);
        w_new = sigma1(win[14]) + win[9] + sigma0(win[1]) + win[0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            t_ctr <= '0;
        end else if (load) begin
            state <= ACTIVE;
            t_ctr <= '0;
        end else if (adv) begin
            t_ctr <= t_ctr + 6'd1;
        end else if (done) begin
            state <= IDLE;
            t_ctr <= '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < 16; i++) begin
                win[i] <= '0;
            end
        end else if (load) begin
            for (int unsigned i = 0; i < 16; i++) begin
                win[i] <= block[32*(15-i) +: 32];
            end
        end else if (adv) begin
            for (int unsigned i = 0; i < 15; i++) begin
                win[i] <= win[i+1];
            end
            win[15] <= w_new;
`ifdef SHA256_W_SCHED_ZEROIZE_EN
        end else if (done || (state == IDLE)) begin
            for (int unsigned i = 0; i < 16; i++) begin
                win[i] <= '0;
            end
`endif
        end
    end

    assign w       = win[0];
    assign w_valid = (state == ACTIVE);
    assign ready   = (state == IDLE);

endmodule

// File: tb/tb_sha256_w_sched.sv
// Self-checking bench for sha256_w_sched against a full-array schedule model.
// Follows SHA256_W_SCHED_ZEROIZE_EN for the expected idle value of w.
module tb_sha256_w_sched;
    logic         clk;
    logic         reset_n;
    logic         init;
    logic         next;
    logic [511:0] block;
    logic [31:0]  w;
    logic         w_valid;
    logic [5:0]   t_ctr;
    logic         ready;

    int n_checks = 0;
    int n_fail   = 0;
    int cur_t    = 0;
    logic [31:0] mw [64];

    sha256_w_sched #(.ROUNDS(64)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .init    (init),
        .next    (next),
        .block   (block),
        .w       (w),
        .w_valid (w_valid),
        .t_ctr   (t_ctr),
        .ready   (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] s0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] s1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    task automatic build_model(input logic [511:0] b);
        for (int t = 0; t < 16; t++) mw[t] = b[32*(15-t) +: 32];
        for (int t = 16; t < 64; t++)
            mw[t] = s1(mw[t-2]) + mw[t-7] + s0(mw[t-15]) + mw[t-16];
    endtask

    function automatic logic [511:0] rnd_block();
        logic [511:0] r;
        r = '0;
        for (int k = 0; k < 16; k++) r = {r[479:0], 32'($urandom())};
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // one clock with the given pulses; outputs sampled 1 time unit after the edge
    task automatic step(input logic i, input logic n, input logic [511:0] b);
        @(negedge clk);
        init = i; next = n; block = b;
        @(posedge clk);
        #1;
        init = 1'b0; next = 1'b0;
    endtask

    task automatic check_active();
        check("w", w, mw[cur_t]);
        check("t_ctr", 32'(t_ctr), 32'(cur_t));
        check("w_valid", 32'(w_valid), 32'd1);
        check("ready", 32'(ready), 32'd0);
    endtask

    task automatic adv_to(input int target);
        while (cur_t < target) begin
            step(1'b0, 1'b1, rnd_block());
            cur_t++;
            check_active();
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ready"}, 32'(ready), 32'd1);
        check({tag, "_w_valid"}, 32'(w_valid), 32'd0);
        check({tag, "_t_ctr"}, 32'(t_ctr), 32'd0);
        check({tag, "_w"}, w, 32'd0);
    endtask

    logic [511:0] abc;
    logic [511:0] b2;
    logic [511:0] b3;
    logic [31:0]  idle_w;

    initial begin
        init = 1'b0; next = 1'b0; block = '0;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check_reset_vals("idle");

        // padded "abc" block, full schedule with random stalls
        abc = '0;
        abc[511:480] = 32'h61626380;
        abc[31:0]    = 32'h00000018;
        build_model(abc);
        step(1'b1, 1'b0, abc);
        cur_t = 0;
        check_active();
        check("abc_w0", w, 32'h61626380);
        for (int t = 1; t < 64; t++) begin
            step(1'b0, 1'b1, rnd_block());
            cur_t = t;
            check_active();
            if (t == 16) check("abc_w16", w, 32'h61626380);
            if (t == 17) check("abc_w17", w, 32'h000F0000);
            if (t == 18) check("abc_w18", w, 32'h7DA86405);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
                check("stall_w", w, mw[cur_t]);
                check("stall_t", 32'(t_ctr), 32'(cur_t));
            end
        end

        // completion
`ifdef SHA256_W_SCHED_ZEROIZE_EN
        idle_w = 32'd0;
`else
        idle_w = mw[63];
`endif
        step(1'b0, 1'b1, rnd_block());
        check("done_w_valid", 32'(w_valid), 32'd0);
        check("done_ready", 32'(ready), 32'd1);
        check("done_t_ctr", 32'(t_ctr), 32'd0);
        check("done_w", w, idle_w);
        @(posedge clk);
        #1;
        check("idle_w", w, idle_w);

        // load from idle via next, then abort with all-ones via init
        b2 = rnd_block();
        build_model(b2);
        step(1'b0, 1'b1, b2);
        cur_t = 0;
        check_active();
        adv_to(20);
        build_model('1);
        step(1'b1, 1'b0, '1);
        cur_t = 0;
        check_active();
        check("abort_w", w, 32'hFFFFFFFF);
        adv_to(3);

        // init and next together: init wins
        b3 = rnd_block();
        build_model(b3);
        step(1'b1, 1'b1, b3);
        cur_t = 0;
        check_active();
        adv_to(5);

        // 10-cycle stall, block changes meanwhile
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            block = rnd_block();
            @(posedge clk);
            #1;
            check("hold_w", w, mw[5]);
            check("hold_t", 32'(t_ctr), 32'd5);
        end

        // asynchronous reset between edges
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_vals("async_rst");
        @(negedge clk);
        reset_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
